score_tracker: RTL

//  Game-side score keeper feeding the 3-digit seven-segment driver.

---
 rtl/score_tracker_pkg.sv | 22 ++
 rtl/score_sat_add.sv | 28 ++
 rtl/score_tracker.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/score_tracker_pkg.sv
// Shared definitions for the score tracker and the 3-digit display driver.
//   state_t  : FSM state encodings for the score tracker.
//   DISP_MAX : largest value the display driver can show (3 decimal digits).
//   SCORE_W  : width of the binary value handed to the display driver.
//   max_score: helper returning the larger of two score values.
package score_tracker_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  localparam int DISP_MAX = 999;
  localparam int SCORE_W  = 10;

  function automatic logic [SCORE_W-1:0] max_score(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/score_sat_add.sv
// Saturating score adder: adds a 1- or 2-point award to the current score
// and clamps the result at MAX_SCORE so the display never wraps.
//   i_score  in  10  current score
//   i_pts    in  2   points to add
//   o_sum    out 10  min(i_score + i_pts, MAX_SCORE)
module score_sat_add
  import score_tracker_pkg::*;
#(
  parameter int MAX_SCORE = DISP_MAX
) (
  input  logic [SCORE_W-1:0] i_score,
  input  logic [1:0]         i_pts,
  output logic [SCORE_W-1:0] o_sum
);

  // One extra bit so a sum past 1023 cannot alias back below the ceiling.
  logic [SCORE_W:0] w_sum;

  always_comb begin
    w_sum = {1'b0, i_score} + {{(SCORE_W-1){1'b0}}, i_pts};
    if (w_sum > (SCORE_W+1)'(MAX_SCORE)) begin
      o_sum = SCORE_W'(MAX_SCORE);
    end else begin
      o_sum = w_sum[SCORE_W-1:0];
    end
  end

endmodule

// File: rtl/score_tracker.sv
// Game-side score keeper. Counts hits (rising edges of i_hit) and misses in
// a run, awards a combo bonus, keeps the best score and presents either the
// current score or the best on a registered 10-bit display value.
//   i_clk         in  1   system clock, rising edge
//   i_rst         in  1   asynchronous active-high reset
//   i_start       in  1   pulse: begin (or restart) a run
//   i_hit         in  1   hit level; scored on its rising edge only
//   i_miss        in  1   pulse: missed beat, clears the combo
//   i_over        in  1   pulse: run ended
//   o_disp_value  out 10  best when o_show_best, else score (1-cycle lag)
//   o_show_best   out 1   display is showing best
//   o_playing     out 1   run in progress
//   o_combo       out 8   consecutive-hit count
//
// state  | meaning
// S_IDLE | after reset, nothing shown, waiting for the first start
// S_PLAY | run in progress, hits and misses scored
// S_OVER | run ended, display alternates score / best
module score_tracker
  import score_tracker_pkg::*;
#(
  parameter int MAX_SCORE   = DISP_MAX,
  parameter int COMBO_STEP  = 10,
  parameter int MAX_COMBO   = 255,
  parameter int FLIP_CYCLES = 1000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_hit,
  input  logic               i_miss,
  input  logic               i_over,
  output logic [SCORE_W-1:0] o_disp_value,
  output logic               o_show_best,
  output logic               o_playing,
  output logic [7:0]         o_combo
);

  localparam int FLIP_W = (FLIP_CYCLES > 1) ? $clog2(FLIP_CYCLES) : 1;
  localparam logic [FLIP_W-1:0] FLIP_LAST  = FLIP_W'(FLIP_CYCLES - 1);
  localparam logic [7:0]        COMBO_BONUS = 8'(COMBO_STEP);
  localparam logic [7:0]        COMBO_SAT   = 8'(MAX_COMBO);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_restart;
  logic                r_hit_q;
  logic                w_hit_rise;
  logic [SCORE_W-1:0]  r_score;
  logic [SCORE_W-1:0]  r_best;
  logic [SCORE_W-1:0]  r_disp;
  logic [SCORE_W-1:0]  w_score_sum;
  logic [1:0]          w_pts;
  logic [7:0]          r_combo;
  logic [FLIP_W-1:0]   r_flip;
  logic                r_show_best;
  logic                r_playing;

  assign w_hit_rise = i_hit & ~r_hit_q;
  // Bonus decision uses the combo before this hit is counted.
  assign w_pts      = (r_combo >= COMBO_BONUS) ? 2'd2 : 2'd1;

  score_sat_add #(
    .MAX_SCORE (MAX_SCORE)
  ) u_sat_add (
    .i_score (r_score),
    .i_pts   (w_pts),
    .o_sum   (w_score_sum)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // over outranks start in PLAY; start alone in PLAY restarts the run.
  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_PLAY;
          w_restart   = 1'b1;
        end
      end
      S_PLAY: begin
        if (i_over) begin
          w_state_nxt = S_OVER;
        end else if (i_start) begin
          w_restart   = 1'b1;
        end
      end
      S_OVER: begin
        if (i_start) begin
          w_state_nxt = S_PLAY;
          w_restart   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hit_q     <= 1'b0;
      r_score     <= '0;
      r_best      <= '0;
      r_combo     <= '0;
      r_flip      <= '0;
      r_show_best <= 1'b0;
      r_disp      <= '0;
      r_playing   <= 1'b0;
    end else begin
      // Edge detector runs in every state so a level held across start is
      // not mistaken for a fresh hit.
      r_hit_q   <= i_hit;
      r_disp    <= r_show_best ? r_best : r_score;
      r_playing <= (w_state_nxt == S_PLAY);

      if (w_restart) begin
        r_score     <= '0;
        r_combo     <= '0;
        r_flip      <= '0;
        r_show_best <= 1'b0;
      end else begin
        case (r_state)
          S_PLAY: begin
            if (i_over) begin
              r_best <= max_score(r_best, r_score);
              r_flip <= '0;
            end else if (i_miss) begin
              r_combo <= '0;
            end else if (w_hit_rise) begin
              r_score <= w_score_sum;
              if (r_combo != COMBO_SAT) begin
                r_combo <= r_combo + 8'd1;
              end
            end
          end
          S_OVER: begin
            if (r_flip == FLIP_LAST) begin
              r_flip      <= '0;
              r_show_best <= ~r_show_best;
            end else begin
              r_flip <= r_flip + FLIP_W'(1);
            end
          end
          default: begin
            r_show_best <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_disp_value = r_disp;
  assign o_show_best  = r_show_best;
  assign o_playing    = r_playing;
  assign o_combo      = r_combo;

endmodule
